// File: rtl/rng_scheduler.sv
// Shares one external LFSR among NUM_REQ requesters: round-robin arbitration, LFSR warm-up,
// and rejection sampling of a value below each requester's limit.
module rng_scheduler #(
    parameter int unsigned         NUM_REQ      = 4,
    parameter int unsigned         NUM_BITS     = 16,
    parameter int unsigned         OUT_BITS     = 8,
    parameter int unsigned         WARMUP       = 4,
    parameter int unsigned         MAX_RETRY    = 3,
    parameter logic [NUM_BITS-1:0] SEED_DEFAULT = NUM_BITS'(1)
) (
    input  logic                        clk_i,
    input  logic                        rst_ni,
    input  logic                        seed_req_i,
    input  logic [NUM_BITS-1:0]         seed_data_i,
    input  logic [NUM_REQ-1:0]          req_i,
    input  logic [NUM_REQ*OUT_BITS-1:0] limit_i,
    output logic [NUM_REQ-1:0]          gnt_o,
    output logic [OUT_BITS-1:0]         rnd_o,
    output logic                        busy_o,
    output logic                        lfsr_en_o,
    output logic                        lfsr_seed_o,
    output logic [NUM_BITS-1:0]         lfsr_seed_data_o,
    input  logic [NUM_BITS-1:0]         lfsr_data_i
);

    localparam int unsigned IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
    localparam int unsigned CNT_W = $clog2(WARMUP + 1);
    localparam int unsigned RET_W = $clog2(MAX_RETRY + 1);

    typedef enum logic [2:0] {
        S_SEED,
        S_IDLE,
        S_STEP,
        S_SAMPLE,
        S_DONE
    } state_t;

    state_t              state_q, state_d;
    logic                pending_q, pending_d;
    logic [NUM_BITS-1:0] seed_q, seed_d;
    logic [IDX_W-1:0]    win_q, win_d;
    logic [OUT_BITS-1:0] limit_q, limit_d;
    logic [CNT_W-1:0]    cnt_q, cnt_d;
    logic [RET_W-1:0]    retry_q, retry_d;
    logic [OUT_BITS-1:0] rnd_q, rnd_d;
    logic [IDX_W-1:0]    rr_q, rr_d;

    logic                found_c;
    logic [IDX_W-1:0]    sel_c;
    logic [OUT_BITS-1:0] sel_limit_c;
    logic [OUT_BITS-1:0] mask_c;
    logic [OUT_BITS-1:0] cand_c;
    logic                accept_c;
    logic                en_c;
    logic                seed_c;
    logic [NUM_REQ-1:0]  gnt_c;

    // Round-robin search starting at rr_q, wrapping modulo NUM_REQ
    always_comb begin
        found_c = 1'b0;
        sel_c   = '0;
        for (int unsigned i = 0; i < NUM_REQ; i++) begin
            int unsigned j;
            j = i + 32'(rr_q);
            if (j >= NUM_REQ) j = j - NUM_REQ;
            if (!found_c && req_i[IDX_W'(j)]) begin
                found_c = 1'b1;
                sel_c   = IDX_W'(j);
            end
        end
        sel_limit_c = '0;
        for (int unsigned i = 0; i < NUM_REQ; i++) begin
            if (sel_c == IDX_W'(i)) sel_limit_c = limit_i[i*OUT_BITS +: OUT_BITS];
        end
    end

    // Smearing limit-1 rightwards yields the smallest 2^k-1 covering it
    always_comb begin
        mask_c = limit_q - OUT_BITS'(1);
        for (int unsigned s = 1; s < OUT_BITS; s = s * 2) begin
            mask_c = mask_c | (mask_c >> s);
        end
        if (limit_q == '0) mask_c = '1;
        cand_c   = lfsr_data_i[OUT_BITS-1:0] & mask_c;
        accept_c = (limit_q == '0) || (cand_c < limit_q);
    end

    always_comb begin
        state_d = state_q;
        win_d   = win_q;
        limit_d = limit_q;
        cnt_d   = cnt_q;
        retry_d = retry_q;
        rnd_d   = rnd_q;
        rr_d    = rr_q;
        en_c    = 1'b0;
        seed_c  = 1'b0;
        gnt_c   = '0;

        case (state_q)
            S_SEED: begin
                en_c    = 1'b1;
                seed_c  = 1'b1;
                state_d = S_IDLE;
            end
            S_IDLE: begin
                if (pending_q || seed_req_i) begin
                    state_d = S_SEED;
                end else if (found_c) begin
                    win_d   = sel_c;
                    limit_d = sel_limit_c;
                    cnt_d   = CNT_W'(WARMUP);
                    retry_d = '0;
                    state_d = S_STEP;
                end
            end
            S_STEP: begin
                en_c = 1'b1;
                if (cnt_q == CNT_W'(1)) state_d = S_SAMPLE;
                else                    cnt_d   = cnt_q - CNT_W'(1);
            end
            S_SAMPLE: begin
                if (accept_c) begin
                    rnd_d   = cand_c;
                    state_d = S_DONE;
                end else if (retry_q < RET_W'(MAX_RETRY)) begin
                    en_c    = 1'b1;
                    retry_d = retry_q + RET_W'(1);
                end else begin
                    rnd_d   = cand_c - limit_q;
                    state_d = S_DONE;
                end
            end
            S_DONE: begin
                gnt_c[win_q] = 1'b1;
                rr_d         = (win_q == IDX_W'(NUM_REQ - 1)) ? '0 : win_q + IDX_W'(1);
                state_d      = S_IDLE;
            end
            default: state_d = S_SEED;
        endcase

        pending_d = seed_req_i ? 1'b1 : ((state_q == S_SEED) ? 1'b0 : pending_q);
        seed_d    = seed_req_i ? seed_data_i : seed_q;
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q   <= S_SEED;
            pending_q <= 1'b0;
            seed_q    <= SEED_DEFAULT;
            win_q     <= '0;
            limit_q   <= '0;
            cnt_q     <= '0;
            retry_q   <= '0;
            rnd_q     <= '0;
            rr_q      <= '0;
        end else begin
            state_q   <= state_d;
            pending_q <= pending_d;
            seed_q    <= seed_d;
            win_q     <= win_d;
            limit_q   <= limit_d;
            cnt_q     <= cnt_d;
            retry_q   <= retry_d;
            rnd_q     <= rnd_d;
            rr_q      <= rr_d;
        end
    end

    // Reset parks the FSM in SEED, so LFSR controls are gated until release
    assign lfsr_en_o        = en_c & rst_ni;
    assign lfsr_seed_o      = seed_c & rst_ni;
    assign gnt_o            = gnt_c;
    assign rnd_o            = rnd_q;
    assign busy_o           = (state_q != S_IDLE);
    assign lfsr_seed_data_o = (seed_q == '1) ? '0 : seed_q;

    generate
        if (NUM_BITS > OUT_BITS) begin : g_unused_hi
            logic unused_hi;
            assign unused_hi = ^lfsr_data_i[NUM_BITS-1:OUT_BITS];
        end
    endgenerate

endmodule

// File: tb/tb_rng_scheduler.sv
// Bench for rng_scheduler: bench drives lfsr_data_i directly; expected grants are queued
// when stimulus is applied and checked when gnt_o fires.
module tb_rng_scheduler;

    localparam int unsigned NR = 4;
    localparam int unsigned NB = 16;
    localparam int unsigned OB = 8;
    localparam int unsigned WU = 4;

    logic             clk = 1'b0;
    logic             rst_ni;
    logic             seed_req_i;
    logic [NB-1:0]    seed_data_i;
    logic [NR-1:0]    req_i;
    logic [NR*OB-1:0] limit_i;
    logic [NR-1:0]    gnt_o;
    logic [OB-1:0]    rnd_o;
    logic             busy_o;
    logic             lfsr_en_o;
    logic             lfsr_seed_o;
    logic [NB-1:0]    lfsr_seed_data_o;
    logic [NB-1:0]    lfsr_data_i;

    always #5 clk = ~clk;

    rng_scheduler #(
        .NUM_REQ     (NR),
        .NUM_BITS    (NB),
        .OUT_BITS    (OB),
        .WARMUP      (WU),
        .MAX_RETRY   (3),
        .SEED_DEFAULT(16'h0001)
    ) dut (
        .clk_i           (clk),
        .rst_ni          (rst_ni),
        .seed_req_i      (seed_req_i),
        .seed_data_i     (seed_data_i),
        .req_i           (req_i),
        .limit_i         (limit_i),
        .gnt_o           (gnt_o),
        .rnd_o           (rnd_o),
        .busy_o          (busy_o),
        .lfsr_en_o       (lfsr_en_o),
        .lfsr_seed_o     (lfsr_seed_o),
        .lfsr_seed_data_o(lfsr_seed_data_o),
        .lfsr_data_i     (lfsr_data_i)
    );

    typedef struct {
        logic [NR-1:0] gnt;
        logic [OB-1:0] rnd;
        int unsigned   lat;
        int unsigned   en;
    } exp_t;

    typedef struct {
        int unsigned   idx;
        logic [OB-1:0] limit;
        logic [NB-1:0] lfsr;
        logic [OB-1:0] rnd;
        int unsigned   retries;
    } vec_t;

    exp_t          sb[$];
    vec_t          vecs[10];
    int unsigned   pass_cnt  = 0;
    int unsigned   total_cnt = 0;
    logic [OB-1:0] prev_rnd  = '0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total_cnt++;
        if (act === exp) pass_cnt++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    endtask

    task automatic push_exp(input logic [NR-1:0] g, input logic [OB-1:0] r,
                            input int unsigned lat, input int unsigned en);
        exp_t e;
        e.gnt = g;
        e.rnd = r;
        e.lat = lat;
        e.en  = en;
        sb.push_back(e);
    endtask

    // Counts edges until a grant, tallying LFSR enables and checking rnd_o holds meanwhile
    task automatic wait_grant(input string tag, input bit scramble);
        exp_t        e;
        int unsigned n = 0;
        int unsigned en = 0;
        bit          got = 1'b0;
        bit          hold_ok = 1'b1;
        while (!got && n < 60) begin
            @(posedge clk);
            #1;
            n++;
            if (lfsr_en_o) en++;
            if (scramble && n == 1) limit_i = $urandom;
            if (gnt_o != '0) got = 1'b1;
            else if (rnd_o !== prev_rnd) hold_ok = 1'b0;
        end
        e = sb.pop_front();
        chk({tag, "_seen"}, 32'(got), 32'd1);
        chk({tag, "_gnt"}, 32'(gnt_o), 32'(e.gnt));
        chk({tag, "_rnd"}, 32'(rnd_o), 32'(e.rnd));
        chk({tag, "_lat"}, n, e.lat);
        chk({tag, "_en_cycles"}, en, e.en);
        chk({tag, "_rnd_hold"}, 32'(hold_ok), 32'd1);
        prev_rnd = e.rnd;
    endtask

    initial begin
        bit bad;

        vecs[0] = '{0, 8'd0,   16'hABCD, 8'hCD, 0};
        vecs[1] = '{1, 8'd6,   16'h0007, 8'h01, 3};
        vecs[2] = '{2, 8'd1,   16'h0007, 8'h00, 0};
        vecs[3] = '{3, 8'd100, 16'h1234, 8'h34, 0};
        vecs[4] = '{0, 8'd200, 16'h00FF, 8'h37, 3};
        vecs[5] = '{1, 8'd128, 16'hFFFF, 8'h7F, 0};
        vecs[6] = '{2, 8'd129, 16'h0081, 8'h00, 3};
        vecs[7] = '{3, 8'd255, 16'h00FE, 8'hFE, 0};
        vecs[8] = '{0, 8'd2,   16'h0003, 8'h01, 0};
        vecs[9] = '{1, 8'd3,   16'h0003, 8'h00, 3};

        rst_ni      = 1'b0;
        seed_req_i  = 1'b0;
        seed_data_i = '0;
        req_i       = '0;
        limit_i     = '0;
        lfsr_data_i = '0;

        // Reset state and the automatic seed cycle after release
        #3;
        chk("rst_gnt", 32'(gnt_o), 32'h0);
        chk("rst_rnd", 32'(rnd_o), 32'h0);
        chk("rst_en", 32'(lfsr_en_o), 32'h0);
        chk("rst_seed", 32'(lfsr_seed_o), 32'h0);
        repeat (3) @(negedge clk);
        rst_ni = 1'b1;
        #1;
        chk("boot_en", 32'(lfsr_en_o), 32'h1);
        chk("boot_seed", 32'(lfsr_seed_o), 32'h1);
        chk("boot_seed_data", 32'(lfsr_seed_data_o), 32'h0001);
        chk("boot_busy", 32'(busy_o), 32'h1);
        @(posedge clk);
        #1;
        chk("idle_busy", 32'(busy_o), 32'h0);
        chk("idle_en", 32'(lfsr_en_o), 32'h0);
        chk("idle_seed", 32'(lfsr_seed_o), 32'h0);

        // All four requesting with full-range limits: round-robin 0,1,2,3,0
        @(negedge clk);
        req_i       = 4'b1111;
        limit_i     = '0;
        lfsr_data_i = 16'h005A;
        push_exp(4'b0001, 8'h5A, WU + 2, WU);
        push_exp(4'b0010, 8'h5A, WU + 3, WU);
        push_exp(4'b0100, 8'h5A, WU + 3, WU);
        push_exp(4'b1000, 8'h5A, WU + 3, WU);
        push_exp(4'b0001, 8'h5A, WU + 3, WU);
        wait_grant("rr0", 1'b0);
        wait_grant("rr1", 1'b0);
        wait_grant("rr2", 1'b0);
        wait_grant("rr3", 1'b0);
        wait_grant("rr4", 1'b0);
        req_i = '0;
        @(posedge clk);

        // Single-requester vectors; limit_i is scrambled after selection
        for (int unsigned k = 0; k < 10; k++) begin
            @(negedge clk);
            limit_i = '1;
            limit_i[vecs[k].idx*OB +: OB] = vecs[k].limit;
            req_i       = 4'(1 << vecs[k].idx);
            lfsr_data_i = vecs[k].lfsr;
            push_exp(4'(1 << vecs[k].idx), vecs[k].rnd, WU + 2 + vecs[k].retries,
                     WU + vecs[k].retries);
            wait_grant($sformatf("vec%0d", k), 1'b1);
            req_i = '0;
            @(posedge clk);
        end

        // All-ones seed is replaced by zero
        @(negedge clk);
        seed_req_i  = 1'b1;
        seed_data_i = 16'hFFFF;
        @(posedge clk);
        #1;
        seed_req_i = 1'b0;
        chk("ones_seed", 32'(lfsr_seed_o), 32'h1);
        chk("ones_en", 32'(lfsr_en_o), 32'h1);
        chk("ones_seed_data", 32'(lfsr_seed_data_o), 32'h0000);
        @(posedge clk);
        #1;
        chk("ones_after_busy", 32'(busy_o), 32'h0);
        chk("ones_after_seed", 32'(lfsr_seed_o), 32'h0);

        // Reseed and request in the same idle cycle: seed wins, grant follows
        @(negedge clk);
        seed_req_i  = 1'b1;
        seed_data_i = 16'h1234;
        req_i       = 4'b0001;
        limit_i     = '0;
        lfsr_data_i = 16'h00A5;
        @(posedge clk);
        #1;
        seed_req_i = 1'b0;
        chk("both_seed", 32'(lfsr_seed_o), 32'h1);
        chk("both_seed_data", 32'(lfsr_seed_data_o), 32'h1234);
        chk("both_gnt", 32'(gnt_o), 32'h0);
        push_exp(4'b0001, 8'hA5, WU + 3, WU);
        wait_grant("seedreq", 1'b0);
        req_i = '0;
        @(posedge clk);

        // Reset during warm-up aborts the transaction
        @(negedge clk);
        req_i       = 4'b0001;
        lfsr_data_i = 16'h0042;
        repeat (2) @(posedge clk);
        #2;
        chk("mid_busy", 32'(busy_o), 32'h1);
        rst_ni = 1'b0;
        #1;
        chk("mid_rst_gnt", 32'(gnt_o), 32'h0);
        chk("mid_rst_en", 32'(lfsr_en_o), 32'h0);
        chk("mid_rst_seed", 32'(lfsr_seed_o), 32'h0);
        chk("mid_rst_rnd", 32'(rnd_o), 32'h0);
        req_i = '0;
        repeat (2) @(negedge clk);
        rst_ni = 1'b1;
        #1;
        chk("mid_rel_en", 32'(lfsr_en_o), 32'h1);
        chk("mid_rel_seed", 32'(lfsr_seed_o), 32'h1);
        chk("mid_rel_seed_data", 32'(lfsr_seed_data_o), 32'h0001);
        bad = 1'b0;
        repeat (12) begin
            @(posedge clk);
            #1;
            if (gnt_o != '0) bad = 1'b1;
        end
        chk("mid_no_grant", 32'(bad), 32'h0);

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule
